// File: rtl/interp_feed_pacer.sv
`default_nettype none
// ============================================================================
// Module      : interp_feed_pacer
// Description : FIFO-buffered pacer that presents one sample every UPFACTOR
//               clocks to the interpolator and appends NFLUSH zero samples
//               after each last-flagged sample. Define PACER_UFLOW_CNT_EN to
//               add a saturating underflow counter port.
// Revision    : 1.0 - initial release
// ============================================================================
module interp_feed_pacer #(
   parameter int IW       = 16,
   parameter int UPFACTOR = 5,
   parameter int DEPTH    = 16,
   parameter int PRIME    = 2,
   parameter int NFLUSH   = 30
) (
   input  logic                          i_clk,
   input  logic                          i_reset_n,
   input  logic                          i_valid,
   output logic                          o_ready,
   input  logic [IW-1:0]                 i_data,
   input  logic                          i_last,
   output logic                          o_ce,
   output logic [IW-1:0]                 o_sample,
   output logic [$clog2(UPFACTOR)-1:0]   o_phase,
   output logic                          o_busy,
   output logic                          o_underflow,
   output logic [$clog2(DEPTH+1)-1:0]    o_level
`ifdef PACER_UFLOW_CNT_EN
   ,
   output logic [15:0]                   o_uflow_cnt
`endif
);

   localparam int PHW = $clog2(UPFACTOR);
   localparam int PW  = $clog2(DEPTH);
   localparam int LW  = $clog2(DEPTH+1);
   localparam int FW  = $clog2(NFLUSH+1);

   localparam logic [PHW-1:0] c_PH_LAST    = PHW'(UPFACTOR-1);
   localparam logic [LW-1:0]  c_DEPTH      = LW'(DEPTH);
   localparam logic [LW-1:0]  c_PRIME      = LW'(PRIME);
   localparam logic [FW-1:0]  c_FLUSH_INIT = FW'(NFLUSH-1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_FLUSH = 2'd2
   } state_t;

   state_t             r_state;
   logic [PHW-1:0]     r_phase;
   logic [IW-1:0]      r_sample;
   logic               r_cur_last;
   logic [FW-1:0]      r_flush_cnt;
   logic               r_ce;
   logic               r_underflow;

   logic [IW:0]        r_mem [DEPTH];
   logic [PW-1:0]      r_wr_ptr;
   logic [PW-1:0]      r_rd_ptr;
   logic [LW-1:0]      r_level;
   logic [LW-1:0]      r_last_cnt;

   logic               w_push;
   logic               w_pop;
   logic               w_start;
   logic               w_wrap;
   logic               w_nonempty;
   logic               w_last_pend;
   logic [IW:0]        w_head;

   assign o_ready     = (r_level != c_DEPTH);
   assign w_push      = i_valid && o_ready;
   assign w_nonempty  = (r_level != '0);
   assign w_head      = r_mem[r_rd_ptr];
   assign w_wrap      = (r_phase == c_PH_LAST);
   // Count of buffered last-flagged entries; robust when several bursts queue up.
   assign w_last_pend = (r_last_cnt != '0);
   assign w_start     = (r_state == S_IDLE) && ((r_level >= c_PRIME) || w_last_pend);
   assign w_pop       = w_start ||
                        ((r_state == S_RUN) && w_wrap && !r_cur_last && w_nonempty);

   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {i_last, i_data};
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_level    <= '0;
         r_last_cnt <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
         case ({w_push && i_last, w_pop && w_head[IW]})
            2'b10:   r_last_cnt <= r_last_cnt + 1'b1;
            2'b01:   r_last_cnt <= r_last_cnt - 1'b1;
            default: r_last_cnt <= r_last_cnt;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state     <= S_IDLE;
         r_phase     <= '0;
         r_sample    <= '0;
         r_cur_last  <= 1'b0;
         r_flush_cnt <= '0;
         r_ce        <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_underflow <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_sample   <= w_head[IW-1:0];
                  r_cur_last <= w_head[IW];
                  r_phase    <= '0;
                  r_ce       <= 1'b1;
                  r_state    <= S_RUN;
               end
            end
            S_RUN: begin
               if (w_wrap) begin
                  r_phase <= '0;
                  if (r_cur_last) begin
                     r_sample    <= '0;
                     r_cur_last  <= 1'b0;
                     r_flush_cnt <= c_FLUSH_INIT;
                     r_state     <= S_FLUSH;
                  end else if (w_nonempty) begin
                     r_sample   <= w_head[IW-1:0];
                     r_cur_last <= w_head[IW];
                  end else begin
                     r_sample    <= '0;
                     r_underflow <= 1'b1;
                  end
               end else begin
                  r_phase <= r_phase + 1'b1;
               end
            end
            S_FLUSH: begin
               if (w_wrap) begin
                  r_phase <= '0;
                  if (r_flush_cnt == '0) begin
                     r_ce    <= 1'b0;
                     r_state <= S_IDLE;
                  end else begin
                     r_flush_cnt <= r_flush_cnt - 1'b1;
                  end
               end else begin
                  r_phase <= r_phase + 1'b1;
               end
            end
            default: begin
               r_state  <= S_IDLE;
               r_phase  <= '0;
               r_sample <= '0;
               r_ce     <= 1'b0;
            end
         endcase
      end
   end

`ifdef PACER_UFLOW_CNT_EN
   logic [15:0] r_uflow_cnt;
   logic        w_uflow_evt;

   // Counts in step with the pulse being raised, so both appear on the same edge.
   assign w_uflow_evt = (r_state == S_RUN) && w_wrap && !r_cur_last && !w_nonempty;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_uflow_cnt <= '0;
      end else if (w_uflow_evt && (r_uflow_cnt != 16'hFFFF)) begin
         r_uflow_cnt <= r_uflow_cnt + 1'b1;
      end
   end

   assign o_uflow_cnt = r_uflow_cnt;
`endif

   assign o_ce        = r_ce;
   assign o_sample    = r_sample;
   assign o_phase     = r_phase;
   assign o_busy      = (r_state != S_IDLE);
   assign o_underflow = r_underflow;
   assign o_level     = r_level;

endmodule
`default_nettype wire

// File: tb/tb_interp_feed_pacer.sv
`default_nettype none
// ============================================================================
// Module      : tb_interp_feed_pacer
// Description : Directed self-checking bench for interp_feed_pacer
//               (UPFACTOR=5, DEPTH=16, PRIME=2, NFLUSH=30).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_interp_feed_pacer;

   logic        i_clk;
   logic        i_reset_n;
   logic        i_valid;
   logic        o_ready;
   logic [15:0] i_data;
   logic        i_last;
   logic        o_ce;
   logic [15:0] o_sample;
   logic [2:0]  o_phase;
   logic        o_busy;
   logic        o_underflow;
   logic [4:0]  o_level;
`ifdef PACER_UFLOW_CNT_EN
   logic [15:0] o_uflow_cnt;
`endif

   int n_vec;
   int n_err;

   interp_feed_pacer #(
      .IW(16), .UPFACTOR(5), .DEPTH(16), .PRIME(2), .NFLUSH(30)
   ) u_dut (
      .i_clk       (i_clk),
      .i_reset_n   (i_reset_n),
      .i_valid     (i_valid),
      .o_ready     (o_ready),
      .i_data      (i_data),
      .i_last      (i_last),
      .o_ce        (o_ce),
      .o_sample    (o_sample),
      .o_phase     (o_phase),
      .o_busy      (o_busy),
      .o_underflow (o_underflow),
      .o_level     (o_level)
`ifdef PACER_UFLOW_CNT_EN
      ,
      .o_uflow_cnt (o_uflow_cnt)
`endif
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int nout;
      int idx;
      int last_acc;
      int acc_after_full;
      bit acc;
      bit seen_full;

      n_vec = 0;
      n_err = 0;
      i_reset_n = 1'b0;
      i_valid   = 1'b0;
      i_data    = '0;
      i_last    = 1'b0;

      // Reset state
      #1;
      chk("rst_ready",  o_ready, 1);
      chk("rst_level",  o_level, 0);
      chk("rst_ce",     o_ce, 0);
      chk("rst_busy",   o_busy, 0);
      chk("rst_sample", o_sample, 0);
      chk("rst_uflow",  o_underflow, 0);
      chk("rst_phase",  o_phase, 0);
`ifdef PACER_UFLOW_CNT_EN
      chk("rst_ucnt",   o_uflow_cnt, 0);
`endif
      repeat (3) step();
      i_reset_n = 1'b1;
      repeat (2) step();
      chk("idle_ce", o_ce, 0);

      // Burst 1..4, last on 4
      i_valid = 1'b1; i_data = 16'h0001; i_last = 1'b0;
      step();
      i_data = 16'h0002;
      step();
      chk("b4_ce_before", o_ce, 0);
      chk("b4_level2", o_level, 2);
      i_data = 16'h0003;
      step();
      chk("b4_ce_rise", o_ce, 1);
      i_data = 16'h0004; i_last = 1'b1;
      for (int k = 0; k < 170; k++) begin
         chk("b4_sample", o_sample, (k < 20) ? (k / 5) + 1 : 0);
         chk("b4_phase", o_phase, k % 5);
         chk("b4_ce", o_ce, 1);
         step();
         if (k == 0) begin
            i_valid = 1'b0; i_last = 1'b0;
         end
      end
      chk("b4_ce_fall", o_ce, 0);
      chk("b4_busy_fall", o_busy, 0);
      chk("b4_level_end", o_level, 0);

      // Single last-flagged sample below PRIME
      i_valid = 1'b1; i_data = 16'h7FFF; i_last = 1'b1;
      step();
      i_valid = 1'b0; i_last = 1'b0;
      chk("one_ce_pre", o_ce, 0);
      chk("one_level", o_level, 1);
      step();
      chk("one_ce_rise", o_ce, 1);
      for (int k = 0; k < 155; k++) begin
         chk("one_sample", o_sample, (k < 5) ? 32'h7FFF : 0);
         chk("one_ce", o_ce, 1);
         step();
      end
      chk("one_ce_fall", o_ce, 0);
      chk("one_busy_fall", o_busy, 0);

      // 24 samples with i_valid held high, last on the 24th
      nout = 0; idx = 0; last_acc = 0; acc_after_full = 0; seen_full = 1'b0;
      i_valid = 1'b1; i_data = 16'h0100; i_last = 1'b0;
      for (int cyc = 1; cyc < 600; cyc++) begin
         acc = i_valid && o_ready;
         step();
         if (acc) begin
            if (seen_full) begin
               acc_after_full++;
               if (acc_after_full >= 2) chk("fill_gap", cyc - last_acc, 5);
            end
            last_acc = cyc;
            idx++;
            if (idx == 24) begin
               i_valid = 1'b0; i_last = 1'b0;
            end else begin
               i_data = 16'h0100 + 16'(idx);
               i_last = (idx == 23);
            end
         end
         if (!o_ready && !seen_full) begin
            chk("fill_full_level", o_level, 16);
            seen_full = 1'b1;
         end
         if (o_ce && o_phase == 3'd0 && nout < 24) begin
            chk("fill_order", o_sample, 32'h0100 + nout);
            nout++;
         end
         if (nout > 0 && !o_busy) break;
      end
      chk("fill_seen_full", seen_full, 1);
      chk("fill_accepts", idx, 24);
      chk("fill_outputs", nout, 24);
      chk("fill_ce_end", o_ce, 0);

      // Underflow and resume
      i_valid = 1'b1; i_data = 16'h0010; i_last = 1'b0;
      step();
      i_data = 16'h0020;
      step();
      i_valid = 1'b0;
      step();
      chk("uf_s10", o_sample, 16'h0010);
      repeat (5) step();
      chk("uf_s20", o_sample, 16'h0020);
      chk("uf_none", o_underflow, 0);
      repeat (5) step();
      chk("uf_zero", o_sample, 0);
      chk("uf_pulse1", o_underflow, 1);
      chk("uf_ce", o_ce, 1);
      step();
      chk("uf_pulse1_end", o_underflow, 0);
      repeat (4) step();
      chk("uf_pulse2", o_underflow, 1);
`ifdef PACER_UFLOW_CNT_EN
      chk("uf_cnt", o_uflow_cnt, 2);
`endif
      i_valid = 1'b1; i_data = 16'h0030;
      step();
      i_valid = 1'b0;
      chk("uf_pulse2_end", o_underflow, 0);
      repeat (4) step();
      chk("uf_resume", o_sample, 16'h0030);
      chk("uf_resume_flag", o_underflow, 0);
      chk("uf_resume_phase", o_phase, 0);

      // Async reset mid-run at phase 2 with five entries buffered
      i_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         i_data = 16'h0040 + 16'(i);
         step();
      end
      i_valid = 1'b0;
      step();
      chk("ar_pre_phase", o_phase, 2);
      chk("ar_pre_level", o_level, 5);
      #2;
      i_reset_n = 1'b0;
      #1;
      chk("ar_ce", o_ce, 0);
      chk("ar_sample", o_sample, 0);
      chk("ar_level", o_level, 0);
      chk("ar_ready", o_ready, 1);
      chk("ar_busy", o_busy, 0);
`ifdef PACER_UFLOW_CNT_EN
      chk("ar_ucnt", o_uflow_cnt, 0);
`endif
      repeat (2) @(negedge i_clk);
      i_reset_n = 1'b1;
      for (int k = 0; k < 20; k++) begin
         step();
         chk("ar_post_ce", o_ce, 0);
         chk("ar_post_sample", o_sample, 0);
      end
      chk("ar_post_level", o_level, 0);
      chk("ar_post_busy", o_busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
